// File: rtl/saber_pkg.sv
// saber_pkg: shared Saber constants, sampler FSM states and the sign-magnitude encoder.
package saber_pkg;

    localparam int SM_W        = 4;
    localparam int SM_SIGN_BIT = 3;
    localparam int SM_MAG_W    = 3;
    localparam int SABER_N     = 256;
    localparam int SABER_MU    = 8;

    typedef logic [SM_W-1:0] sm_t;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    // The sign comes from the two's-complement MSB, so zero always encodes as 0000.
    function automatic sm_t sm_encode(input logic signed [4:0] d);
        return {d[4], d[4] ? SM_MAG_W'(-d) : d[SM_MAG_W-1:0]};
    endfunction

endpackage

// File: rtl/cbd_coeff.sv
// cbd_coeff: maps an MU-bit random window to one centered-binomial sign-magnitude coefficient.
module cbd_coeff
    import saber_pkg::*;
#(
    parameter int MU = SABER_MU
) (
    input  logic [MU-1:0] bits,
    output sm_t           sm
);

    logic [3:0] ha, hb;

    // Count the ones in the low half (a) and in the high half (b) of the window.
    always_comb begin
        ha = '0;
        hb = '0;
        for (int i = 0; i < MU / 2; i++) begin
            ha = ha + 4'(bits[i]);
            hb = hb + 4'(bits[i + MU / 2]);
        end
    end

    assign sm = sm_encode(5'(ha) - 5'(hb));

endmodule

// File: rtl/cbd_sm_sampler.sv
// cbd_sm_sampler: streams N_COEFF centered-binomial coefficients in sign-magnitude form from random words.
// Optional macro CBD_SAMPLER_NEG_EN adds a neg input that flips the sign of a whole polynomial.
module cbd_sm_sampler
    import saber_pkg::*;
#(
    parameter int MU      = SABER_MU,
    parameter int IN_W    = 64,
    parameter int N_COEFF = SABER_N
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef CBD_SAMPLER_NEG_EN
    input  logic            neg,
`endif
    input  logic            start,
    input  logic [IN_W-1:0] rnd_in,
    input  logic            rnd_valid,
    output logic            rnd_ready,
    output logic [SM_W-1:0] coeff_out,
    output logic            coeff_valid,
    input  logic            coeff_ready,
    output logic [7:0]      coeff_idx,
    output logic            busy,
    output logic            done
);

    localparam int BUF_W = 2 * IN_W;
    localparam int CNT_W = $clog2(BUF_W + 1);
    localparam int ISS_W = $clog2(N_COEFF + 1);

    generate
        if (MU > 10 || MU % 2 != 0) begin : g_bad_mu
            $error("cbd_sm_sampler: MU must be even and at most 10");
        end
    endgenerate

    state_t           state;
    logic [BUF_W-1:0] bit_buf, merged;
    logic [CNT_W-1:0] bit_cnt, avail;
    logic [ISS_W-1:0] issued;
    logic             accept, load;
    sm_t              raw, coeff_next;

    // Stop asking for words once held plus already-issued bits cover the whole polynomial.
    assign rnd_ready = state == ST_RUN && 32'(bit_cnt) <= 32'(IN_W)
                     && 32'(bit_cnt) + 32'(MU) * 32'(issued) < 32'(MU * N_COEFF);
    assign accept    = rnd_ready && rnd_valid;

    // The incoming word is visible to the coefficient path in the cycle it is accepted.
    assign merged = accept ? bit_buf | (BUF_W'(rnd_in) << bit_cnt) : bit_buf;
    assign avail  = accept ? bit_cnt + CNT_W'(IN_W) : bit_cnt;
    assign load   = state == ST_RUN && 32'(avail) >= 32'(MU) && 32'(issued) < 32'(N_COEFF)
                  && (!coeff_valid || coeff_ready);

    cbd_coeff #(.MU(MU)) u_coeff (
        .bits(merged[MU-1:0]),
        .sm  (raw)
    );

`ifdef CBD_SAMPLER_NEG_EN
    logic neg_q;
    assign coeff_next = raw ^ (SM_W'(neg_q && |raw[SM_MAG_W-1:0]) << SM_SIGN_BIT);

    // Polarity is latched once per polynomial.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) neg_q <= 1'b0;
        else if (start) neg_q <= neg;
    end
`else
    assign coeff_next = raw;
`endif

    // Control FSM, bit buffer and output register; start flushes everything and re-enters RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_buf     <= '0;
            bit_cnt     <= '0;
            issued      <= '0;
            coeff_out   <= '0;
            coeff_valid <= 1'b0;
            coeff_idx   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (start) begin
            state       <= ST_RUN;
            bit_buf     <= '0;
            bit_cnt     <= '0;
            issued      <= '0;
            coeff_out   <= '0;
            coeff_valid <= 1'b0;
            coeff_idx   <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_RUN: begin
                    bit_buf <= load ? merged >> MU : merged;
                    bit_cnt <= load ? avail - CNT_W'(MU) : avail;
                    if (load) begin
                        coeff_out   <= coeff_next;
                        coeff_idx   <= 8'(issued);
                        issued      <= issued + 1'b1;
                        coeff_valid <= 1'b1;
                    end else if (coeff_ready) begin
                        coeff_valid <= 1'b0;
                    end
                    if (coeff_valid && coeff_ready && 32'(coeff_idx) == N_COEFF - 1) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cbd_sm_sampler.sv
// tb_cbd_sm_sampler: directed and randomized-handshake checks of the CBD sampler for MU=8 and MU=10.
module tb_cbd_sm_sampler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0, start10 = 1'b0;
    logic        sel = 1'b0;
    logic        neg = 1'b0;
    logic [63:0] rnd_in = '0;
    logic        rnd_valid = 1'b0;
    logic        coeff_ready = 1'b0;

    logic       rr8, rr10, cv8, cv10, busy8, busy10, done8, done10;
    logic [3:0] co8, co10;
    logic [7:0] idx8, idx10;

    logic       o_rready, o_valid, o_busy, o_done;
    logic [3:0] o_coeff;
    logic [7:0] o_idx;

    logic [63:0] words [0:39];
    logic [3:0]  got [0:255];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    cbd_sm_sampler #(.MU(8), .IN_W(64), .N_COEFF(256)) u8 (
        .clk(clk), .rst_n(rst_n),
`ifdef CBD_SAMPLER_NEG_EN
        .neg(neg),
`endif
        .start(start8), .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rr8),
        .coeff_out(co8), .coeff_valid(cv8), .coeff_ready(coeff_ready), .coeff_idx(idx8),
        .busy(busy8), .done(done8)
    );

    cbd_sm_sampler #(.MU(10), .IN_W(64), .N_COEFF(256)) u10 (
        .clk(clk), .rst_n(rst_n),
`ifdef CBD_SAMPLER_NEG_EN
        .neg(neg),
`endif
        .start(start10), .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rr10),
        .coeff_out(co10), .coeff_valid(cv10), .coeff_ready(coeff_ready), .coeff_idx(idx10),
        .busy(busy10), .done(done10)
    );

    assign o_rready = sel ? rr10 : rr8;
    assign o_valid  = sel ? cv10 : cv8;
    assign o_coeff  = sel ? co10 : co8;
    assign o_idx    = sel ? idx10 : idx8;
    assign o_busy   = sel ? busy10 : busy8;
    assign o_done   = sel ? done10 : done8;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference: count bits straight out of the word stream.
    function automatic logic [3:0] model(input int k, input int mu);
        int a = 0, b = 0, d, p;
        for (int j = 0; j < mu; j++) begin
            p = k * mu + j;
            if (j < mu / 2) a += int'(words[p / 64][p % 64]);
            else            b += int'(words[p / 64][p % 64]);
        end
        d = a - b;
        if (neg && d != 0) d = -d;
        return {d < 0, 3'(d < 0 ? -d : d)};
    endfunction

    task automatic check_model(input int mu);
        for (int k = 0; k < 256; k++) check($sformatf("coef%0d", k), got[k], model(k, mu));
    endtask

    task automatic fill_random(input int nw);
        for (int i = 0; i < nw; i++) words[i] = {$urandom, $urandom};
    endtask

    task automatic run(input int nw, input int ncoef, input int vprob, input int rprob,
                       input bit full, input int abort_at);
        int wi = 0, cnt = 0, cy = 0, acc_cy = -1, val_cy = -1, extra = 0, ndone = 0;
        bit held = 0;
        logic [3:0] hc = '0;
        logic [7:0] hi = '0;
        for (int k = 0; k < 256; k++) got[k] = 4'hF;
        @(posedge clk); #1;
        if (sel) start10 = 1'b1; else start8 = 1'b1;
        rnd_valid = 1'b0;
        coeff_ready = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        start10 = 1'b0;
        check("flush", {o_valid, o_busy, o_idx}, {1'b0, 1'b1, 8'd0});
        while (!(cnt == ncoef && (!full || ndone > 0)) && cnt != abort_at && cy < 4000) begin
            if (held) check("hold", {o_valid, o_idx, o_coeff}, {1'b1, hi, hc});
            if (o_done) ndone++;
            if (o_valid && val_cy < 0) val_cy = cy;
            coeff_ready = $urandom_range(99) < rprob;
            if (o_valid && coeff_ready) begin
                check("idx", o_idx, cnt[7:0]);
                if (cnt < 256) got[cnt] = o_coeff;
                cnt++;
            end
            held = o_valid && !coeff_ready;
            hc = o_coeff;
            hi = o_idx;
            if (wi < nw) begin
                rnd_in = words[wi];
                rnd_valid = $urandom_range(99) < vprob;
                if (rnd_valid && o_rready) begin
                    if (acc_cy < 0) acc_cy = cy;
                    wi++;
                end
            end else begin
                rnd_in = {$urandom, $urandom};
                rnd_valid = full;
                if (full && o_rready) extra++;
            end
            @(posedge clk); #1;
            cy++;
        end
        check("timeout", cy < 4000, 1);
        if (abort_at < 0) begin
            check("count", cnt, ncoef);
            check("latency", val_cy, acc_cy + 1);
            rnd_valid = 1'b0;
            coeff_ready = 1'b1;
            repeat (4) begin
                @(posedge clk); #1;
                if (o_valid) extra++;
                if (o_done) ndone++;
            end
            check("extra", extra, 0);
            check("done_pulses", ndone, full ? 1 : 0);
            check("busy_end", o_busy, !full);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset8", {rr8, cv8, co8, idx8, busy8, done8}, 16'h0);
        check("reset10", {rr10, cv10, co10, idx10, busy10, done10}, 16'h0);
        rst_n = 1'b1;

        words[0] = 64'h0F0F_0F0F_0F0F_0F0F;
        run(1, 8, 100, 100, 1'b0, -1);
        for (int k = 0; k < 8; k++) check($sformatf("plus4_%0d", k), got[k], 4'b0100);

        words[0] = 64'h0000_0000_0000_FFF0;
        run(1, 8, 100, 100, 1'b0, -1);
        check("minus4", got[0], 4'b1100);
        for (int k = 1; k < 8; k++) check($sformatf("zero_%0d", k), got[k], 4'b0000);

        fill_random(32);
        run(32, 256, 70, 60, 1'b1, -1);
        check_model(8);

        fill_random(32);
        run(32, 256, 80, 80, 1'b1, 100);
        fill_random(32);
        run(32, 256, 80, 70, 1'b1, -1);
        check_model(8);

        fill_random(32);
        run(32, 256, 80, 80, 1'b1, 50);
        rst_n = 1'b0;
        #1;
        check("midrun_reset", {o_rready, o_valid, o_coeff, o_idx, o_busy, o_done}, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fill_random(32);
        run(32, 256, 75, 75, 1'b1, -1);
        check_model(8);

        sel = 1'b1;
        fill_random(40);
        words[0] = 64'hF000_0000_0000_0000;
        words[1] = 64'h0;
        run(40, 256, 75, 65, 1'b1, -1);
        check("straddle6", got[6], 4'b0100);
        check_model(10);
        sel = 1'b0;

`ifdef CBD_SAMPLER_NEG_EN
        neg = 1'b1;
        words[0] = 64'h0000_0000_0000_000F;
        run(1, 8, 100, 100, 1'b0, -1);
        check("neg_first", got[0], 4'b1100);
        for (int k = 1; k < 8; k++) check($sformatf("neg_zero_%0d", k), got[k], 4'b0000);
        neg = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cbd_sm_sampler.md
Name: cbd_sm_sampler

Overview:
- Centered-binomial sampler that generates Saber secret polynomials.
- Consumes a stream of pseudorandom words from the SHAKE output path.
- Emits 256 small coefficients, one per handshake, in the 4-bit sign-magnitude format consumed by the polynomial-multiplier small ALUs: bit3 = sign (1 = negative), bits2:0 = magnitude 0..5.
- Acts as the producer end of the secret-coefficient interface into the multiplier's secret buffer.

Parameters:
- MU, 8, binomial parameter (even; 6/8/10 for Fire/Saber/LightSaber); coefficient = HW(low MU/2 bits) - HW(next MU/2 bits).
- IN_W, 64, random input word width.
- N_COEFF, 256, coefficients per polynomial.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; begins a new polynomial and clears all internal state.
- rnd_in  in  IN_W  random bits, consumed LSB first.
- rnd_valid  in  1  rnd_in valid.
- rnd_ready  out  1  sampler accepts rnd_in this cycle.
- coeff_out  out  4  sign-magnitude coefficient.
- coeff_valid  out  1  coeff_out valid.
- coeff_ready  in  1  consumer accepts coeff_out.
- coeff_idx  out  8  index (0..N_COEFF-1) of coeff_out.
- busy  out  1  high in RUN.
- done  out  1  1-cycle pulse after the last coefficient handshake.

Behaviour:
- Reset: state = IDLE; bit buffer, bit_cnt and emit counter cleared; rnd_ready, coeff_out, coeff_valid, coeff_idx, busy and done all 0.
- States:
  - IDLE -(start)-> RUN.
  - RUN -(handshake of coefficient N_COEFF-1)-> DONE.
  - DONE -> IDLE after 1 cycle; done = 1 only in DONE.
  - start in any state re-enters RUN: buffer, bit_cnt, counters and output register are flushed; a pending coeff_valid drops the next cycle.
- Bit buffer: 2*IN_W bits, plus bit_cnt (0..2*IN_W).
  - Accepted word is appended at bit position bit_cnt, after any same-cycle shift.
  - Emit consumes buffer[MU-1:0] and shifts right by MU.
  - Accept and emit in the same cycle: bit_cnt_next = bit_cnt + IN_W - MU.
- rnd_ready = RUN && bit_cnt <= IN_W && (bit_cnt + MU*issued) < MU*N_COEFF.
  - Computed from registered state only.
  - Guarantees no surplus word is accepted after enough bits are held for the polynomial.
  - Leftover bits at polynomial end are discarded.
- Output register:
  - Loads when (RUN, bit_cnt >= MU, issued < N_COEFF) and (!coeff_valid or coeff_ready).
  - Holds value and coeff_idx stable while coeff_valid && !coeff_ready.
  - Sustains one coefficient per cycle.
- Latency: a word accepted in cycle t (buffer previously empty) gives coeff_valid at t+1.
- Arithmetic:
  - d = HW(a) - HW(b), range -MU/2..MU/2.
  - Output {d<0, |d|[2:0]}.
  - Zero is always 4'b0000, never 4'b1000.
- MU > 10 is illegal: elaboration error via generate-time check.

Optional Feature:
- Macro CBD_SAMPLER_NEG_EN.
- Enabled:
  - Adds input port neg (1 bit), sampled at start.
  - When latched high, the sign of every nonzero coefficient of that polynomial is inverted, so the multiplier computes a subtraction without an extra pass.
  - Zero stays 0000.
- Disabled: no neg port; coefficients are emitted as sampled.

Decomposition:
- Shared package saber_pkg holds:
  - SM_W = 4, SM_SIGN_BIT = 3, SM_MAG_W = 3.
  - SABER_N = 256, default MU.
  - The sign-magnitude encode function, reused by the multiplier bench model.
- Combinational sub-module cbd_coeff (MU-bit input -> 4-bit sign-magnitude) covers popcounts, subtract and encode; it is unit-testable in isolation.

Test Plan:
- MU=8, rnd_in=64'h0F0F_0F0F_0F0F_0F0F, coeff_ready=1 -> 8 coefficients of 4'b0100 (+4), first at cycle after accept, coeff_idx 0..7.
- MU=8, word 64'h0000_0000_0000_FFF0 -> coefficients 1100 (-4), 0000 (the byte 0xFF), then 0000 ×6; never 1000.
- Full polynomial MU=8, 32 random words with random rnd_valid gaps and random coeff_ready stalls -> 256 coefficients matching the reference model, output held stable during stalls, rnd_ready low after word 32, one done pulse.
- MU=10, 40 words -> coefficients straddle word boundaries (coefficient 6 uses bits 60..63 of word 0 and bits 0..5 of word 1), 256 emitted, rnd_ready stays 0 once 2560 bits have been accepted.
- start pulsed at coefficient 100, and separately rst_n asserted mid-run -> immediate flush; restart emits from coeff_idx 0 with no stale bits; after reset all outputs are 0.
- CBD_SAMPLER_NEG_EN, neg=1, word 64'h0F -> first coefficient 1100, zeros remain 0000.
